// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: Gray/binary conversion and
// depth derivation, used by both the write-side and read-side flag logic.
package fifo_ptr_pkg;

    localparam int FIFO_ADDR_W  = 3;
    localparam int FIFO_DEPTH   = 1 << FIFO_ADDR_W;
    localparam int PTR_FN_W     = 32;

    // Number of RAM words addressed by an addr_w-bit address.
    function automatic int fifo_depth(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

    function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] gray);
        logic [PTR_FN_W-1:0] bin;
        logic                acc;
        bin = {PTR_FN_W{1'b0}};
        acc = 1'b0;
        for (int i = PTR_FN_W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// Parameterised Gray-to-binary converter (XOR prefix from the MSB down).
module gray_to_binary #(
    parameter int width = 4
) (
    input  logic [width-1:0] gray_i,
    output logic [width-1:0] binary_o
);

    // Bit i of the binary value is the XOR-reduction of gray bits [width-1:i].
    always_comb begin
        binary_o = {width{1'b0}};
        for (int i = 0; i < width; i++) begin
            binary_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/write_full_ctrl.sv
// Write-domain pointer and flag controller for the async FIFO: binary/Gray
// write pointers, RAM write strobe, and registered full/almost-full/level/overflow.
module write_full_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int address   = 3,
    parameter int af_margin = 2
) (
    input  logic               write_clk,
    input  logic               write_rst,
    input  logic               write_inc,
    input  logic               ovf_clr,
    input  logic [address:0]   sync_read_ptr,
    output logic [address:0]   write_ptr,
    output logic [address-1:0] write_addr,
    output logic               write_en,
    output logic               write_full,
    output logic               write_almost_full,
    output logic [address:0]   write_level,
    output logic               write_overflow
);

    localparam int             DEPTH     = fifo_depth(address);
    localparam logic [address:0] AF_THRESH = (address+1)'(DEPTH - af_margin);

    logic [address:0] binary_q, binary_d;
    logic [address:0] gray_q,   gray_d;
    logic [address:0] level_q,  level_d;
    logic             full_q,   full_d;
    logic             af_q,     af_d;
    logic             ovf_q,    ovf_d;
    logic             write_en_s;
    logic [address:0] rbin_s;
    logic [address:0] full_cmp_s;

    gray_to_binary #(
        .width (address + 1)
    ) u_rptr_g2b (
        .gray_i   (sync_read_ptr),
        .binary_o (rbin_s)
    );

    // Next-state: pointer advance and flags evaluated on the post-write pointer.
    always_comb begin
        write_en_s = write_inc & ~full_q;
        binary_d   = binary_q + {{address{1'b0}}, write_en_s};
        gray_d     = (address+1)'(bin2gray(PTR_FN_W'(binary_d)));
        level_d    = binary_d - rbin_s;
        // Full when the write pointer has lapped the read pointer exactly once.
        full_cmp_s = {~sync_read_ptr[address -: 2], sync_read_ptr[address-2:0]};
        full_d     = (gray_d == full_cmp_s);
        af_d       = (level_d >= AF_THRESH);
        if (write_inc && full_q) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; write_ptr comes straight from gray_q so only one bit toggles per edge.
    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            binary_q <= {(address+1){1'b0}};
            gray_q   <= {(address+1){1'b0}};
            level_q  <= {(address+1){1'b0}};
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            binary_q <= binary_d;
            gray_q   <= gray_d;
            level_q  <= level_d;
            full_q   <= full_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
        end
    end

    assign write_ptr         = gray_q;
    assign write_addr        = binary_q[address-1:0];
    assign write_en          = write_en_s;
    assign write_full        = full_q;
    assign write_almost_full = af_q;
    assign write_level       = level_q;
    assign write_overflow    = ovf_q;

endmodule
